// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared constants and types for the SNN weight path
//             (weight loader, Memory, Multilayer).
//  Revision : 1.0 - initial release
// ============================================================================
package snn_pkg;

  // Default weight memory geometry shared by Memory and Multilayer
  localparam int ADDR_W = 4;
  localparam int DW     = 8;

  // Weight loader control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    LOCKED = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/snn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : snn_sync_edge
//  Purpose  : 3-flop synchroniser for an asynchronous host pin plus a
//             rising-edge detector on the synchronised value.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Shift the pin through three flops; s1 absorbs metastability
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/snn_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : snn_weight_loader
//  Purpose  : Host-facing weight-load front end. Turns each rising edge of
//             the asynchronous host strobe into exactly one weight Memory
//             write, keeps a written-address mask, write count, checksum and
//             overwrite flag, and locks out writes during inference.
//  Options  : SNN_LOADER_PARITY_EN - adds host_parity input and sticky
//             err_parity output; writes failing even parity are dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_weight_loader #(
  parameter int ADDR_W = snn_pkg::ADDR_W,
  parameter int DW     = snn_pkg::DW,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_infer,
  input  logic              host_strobe,
  input  logic              host_clr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DW-1:0]     host_data,
`ifdef SNN_LOADER_PARITY_EN
  input  logic              host_parity,
  output logic              err_parity,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DEPTH-1:0]  written_mask,
  output logic              all_loaded,
  output logic [ADDR_W:0]   wr_count,
  output logic [DW-1:0]     checksum,
  output logic              err_overwrite
);

  import snn_pkg::*;

  loader_state_t     r_state;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic [DEPTH-1:0]  r_mask;
  logic [ADDR_W:0]   r_wr_count;
  logic [DW-1:0]     r_checksum;
  logic              r_err_ow;
  logic              w_rise;
  logic              w_parity_ok;

  // Strobe synchroniser runs in every state so leaving LOCKED never
  // produces a stale edge
  snn_sync_edge u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_strobe),
    .rise     (w_rise)
  );

`ifdef SNN_LOADER_PARITY_EN
  logic r_err_parity;
  // Even parity across data and parity bit must reduce to zero
  assign w_parity_ok = ~(^{host_data, host_parity});
  assign err_parity  = r_err_parity;
`else
  assign w_parity_ok = 1'b1;
`endif

  // Load-control FSM with registered Memory interface and bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mask      <= '0;
      r_wr_count  <= '0;
      r_checksum  <= '0;
      r_err_ow    <= 1'b0;
`ifdef SNN_LOADER_PARITY_EN
      r_err_parity <= 1'b0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (phase_infer) begin
            r_state <= LOCKED;
          end else if (host_clr) begin
            // A coincident strobe edge is deliberately dropped here
            r_mask     <= '0;
            r_wr_count <= '0;
            r_checksum <= '0;
            r_err_ow   <= 1'b0;
`ifdef SNN_LOADER_PARITY_EN
            r_err_parity <= 1'b0;
`endif
          end else if (w_rise) begin
            if (w_parity_ok) begin
              r_mem_we          <= 1'b1;
              r_mem_addr        <= host_addr;
              r_mem_wdata       <= host_data;
              r_mask[host_addr] <= 1'b1;
              r_err_ow          <= r_err_ow | r_mask[host_addr];
              r_checksum        <= r_checksum + host_data;
              if (r_wr_count != '1) begin
                r_wr_count <= r_wr_count + 1'b1;
              end
              r_state <= WRITE;
            end else begin
`ifdef SNN_LOADER_PARITY_EN
              r_err_parity <= 1'b1;
`endif
            end
          end
        end
        WRITE: begin
          r_state <= phase_infer ? LOCKED : IDLE;
        end
        LOCKED: begin
          if (!phase_infer) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign written_mask  = r_mask;
  assign all_loaded    = &r_mask;
  assign wr_count      = r_wr_count;
  assign checksum      = r_checksum;
  assign err_overwrite = r_err_ow;

endmodule
`default_nettype wire

// File: tb/tb_snn_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_weight_loader
//  Purpose  : Self-checking bench for snn_weight_loader. Expected Memory
//             writes (address, data, cycle) are queued by the stimulus and
//             popped by an independent monitor on every mem_we.
//  Options  : SNN_LOADER_PARITY_EN - also exercises the parity path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snn_weight_loader;

  localparam int ADDR_W = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    int                cyc;
  } exp_wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              phase_infer = 1'b0;
  logic              host_strobe = 1'b0;
  logic              host_clr = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DW-1:0]     host_data = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DEPTH-1:0]  written_mask;
  logic              all_loaded;
  logic [ADDR_W:0]   wr_count;
  logic [DW-1:0]     checksum;
  logic              err_overwrite;
`ifdef SNN_LOADER_PARITY_EN
  logic              host_parity = 1'b0;
  logic              err_parity;
`endif

  exp_wr_t exp_q[$];
  int      cyc = 0;
  int      n_cmp = 0;
  int      n_err = 0;

  snn_weight_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phase_infer   (phase_infer),
    .host_strobe   (host_strobe),
    .host_clr      (host_clr),
    .host_addr     (host_addr),
    .host_data     (host_data),
`ifdef SNN_LOADER_PARITY_EN
    .host_parity   (host_parity),
    .err_parity    (err_parity),
`endif
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .written_mask  (written_mask),
    .all_loaded    (all_loaded),
    .wr_count      (wr_count),
    .checksum      (checksum),
    .err_overwrite (err_overwrite)
  );

  always #5 clk = ~clk;

  // Posedge counter, read on negedges where it is stable
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h cyc=%0d required none",
                 mem_addr, mem_wdata, cyc);
      end else begin
        exp_wr_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL write actual addr=0x%0h data=0x%0h cyc=%0d required addr=0x%0h data=0x%0h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // One strobed write; bad_par corrupts parity so no write is expected
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d,
                          input int hold, input bit bad_par);
    exp_wr_t e;
    host_addr = a;
    host_data = d;
`ifdef SNN_LOADER_PARITY_EN
    host_parity = (^d) ^ bad_par;
`endif
    repeat (3) @(negedge clk);
    host_strobe = 1'b1;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 3;
    if (!bad_par) exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    host_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    host_clr = 1'b1;
    @(negedge clk);
    host_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_book(input string tag, input logic [DEPTH-1:0] m, input int cnt,
                            input logic [DW-1:0] cs, input logic ow);
    check({tag, "_mask"}, 32'(written_mask), 32'(m));
    check({tag, "_count"}, 32'(wr_count), 32'(cnt));
    check({tag, "_checksum"}, 32'(checksum), 32'(cs));
    check({tag, "_err_ow"}, 32'(err_overwrite), 32'(ow));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_mem_we", 32'(mem_we), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_all_loaded", 32'(all_loaded), 0);
    check_book("reset", '0, 0, 8'h00, 1'b0);

    // Single write with strobe held for 10 cycles
    do_write(4'h3, 8'hA5, 10, 1'b0);
    check_book("single", 16'h0008, 1, 8'hA5, 1'b0);
    check("single_addr_hold", 32'(mem_addr), 32'h3);
    check("single_data_hold", 32'(mem_wdata), 32'hA5);

    // Full load of all 16 addresses with data i+1
    pulse_clr();
    check_book("clr1", '0, 0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      do_write(ADDR_W'(i), DW'(i + 1), 2, 1'b0);
      if (i == DEPTH - 2) check("partial_all_loaded", 32'(all_loaded), 0);
    end
    check("full_all_loaded", 32'(all_loaded), 1);
    check_book("full", 16'hFFFF, 16, 8'h88, 1'b0);

    // Overwrite of address 5
    pulse_clr();
    do_write(4'h5, 8'h10, 1, 1'b0);
    check("ow_first_flag", 32'(err_overwrite), 0);
    do_write(4'h5, 8'hF0, 3, 1'b0);
    check_book("ow", 16'h0020, 2, 8'h00, 1'b1);

    // Lock: strobes and clear ignored while phase_infer is high
    phase_infer = 1'b1;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      host_addr = 4'h9;
      host_data = 8'h77;
      host_strobe = 1'b1;
      repeat (2) @(negedge clk);
      host_strobe = 1'b0;
      repeat (3) @(negedge clk);
    end
    pulse_clr();
    check_book("locked", 16'h0020, 2, 8'h00, 1'b1);
    host_strobe = 1'b1;
    repeat (3) @(negedge clk);
    phase_infer = 1'b0;
    repeat (6) @(negedge clk);
    host_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("unlock_no_write_count", 32'(wr_count), 2);
    do_write(4'h7, 8'h11, 2, 1'b0);
    check_book("relock", 16'h00A0, 3, 8'h11, 1'b1);

    // Clear coincident with the rise: write dropped, bookkeeping zeroed
    host_addr = 4'h9;
    host_data = 8'h33;
    repeat (3) @(negedge clk);
    host_strobe = 1'b1;
    repeat (2) @(negedge clk);
    host_clr = 1'b1;
    @(negedge clk);
    host_clr = 1'b0;
    repeat (3) @(negedge clk);
    host_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check_book("clr_rise", '0, 0, 8'h00, 1'b0);

    // Reset one cycle after the rise: pending write lost
    do_write(4'h2, 8'h44, 2, 1'b0);
    host_addr = 4'hC;
    host_data = 8'h55;
    repeat (3) @(negedge clk);
    host_strobe = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    host_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check_book("rst", '0, 0, 8'h00, 1'b0);

`ifdef SNN_LOADER_PARITY_EN
    // Parity: bad parity drops the write, good parity accepts it
    do_write(4'h1, 8'h01, 2, 1'b1);
    check("par_bad_flag", 32'(err_parity), 1);
    check("par_bad_count", 32'(wr_count), 0);
    do_write(4'h1, 8'h01, 2, 1'b0);
    check_book("par_good", 16'h0002, 1, 8'h01, 1'b0);
    pulse_clr();
    check("par_clr_flag", 32'(err_parity), 0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_weight_loader.md
Name: snn_weight_loader

Overview:
- Host-facing weight-load front end that sits directly upstream of the weight Memory in tt_um_snn.
- Replaces the free-running "write every cycle" Phase-0 path with a strobed, synchronised, one-write-per-strobe protocol.
- Tracks which addresses are loaded, a running checksum and error flags.
- Locks out all writes while inference (phase_infer=1) is active.

Parameters:
- ADDR_W, 4, weight memory address width.
- DW, 8, weight data width.
- DEPTH, 1<<ADDR_W, number of weight words tracked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- phase_infer  in  1  0 = load phase, 1 = inference (uio_in[0]).
- host_strobe  in  1  asynchronous host write strobe (uio_in[1]); a rising edge requests one write.
- host_clr  in  1  synchronous clear of bookkeeping, level, sampled every cycle.
- host_addr  in  ADDR_W  write address (uio_in[7:4]); host holds it stable ≥3 cycles before and after the strobe edge.
- host_data  in  DW  write data (ui_in); same stability rule as host_addr.
- mem_we  out  1  Memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DW  Memory write data.
- written_mask  out  DEPTH  bit i set once address i has been written.
- all_loaded  out  1  high when written_mask is all ones.
- wr_count  out  ADDR_W+1  number of accepted writes, saturating at 2^(ADDR_W+1)-1.
- checksum  out  DW  sum of all accepted write data, mod 2^DW.
- err_overwrite  out  1  sticky; set when an already-written address is written again.

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0; state = IDLE; synchroniser flops are 0.
- Synchroniser: s1<=host_strobe, s2<=s1, s3<=s2. rise = s2 & ~s3. Flops update in every state, so no spurious edge appears when leaving LOCKED.
- Outputs are registered. mem_addr and mem_wdata hold their last value when mem_we=0.
- FSM states:
  - IDLE: if phase_infer=1 → LOCKED. Else if host_clr=1 → clear written_mask, wr_count, checksum and err_overwrite; any rise in this cycle is discarded; stay in IDLE. Else if rise → register mem_we=1, mem_addr=host_addr, mem_wdata=host_data; update bookkeeping; go to WRITE.
  - WRITE: mem_we<=0; any rise in this cycle is ignored (rise cannot recur within 2 cycles anyway). Go to LOCKED if phase_infer=1, else IDLE.
  - LOCKED: mem_we held 0; rise and host_clr are ignored. When phase_infer=0 → IDLE. Bookkeeping is retained across the lock.
- Latency: host_strobe first sampled high at edge N → mem_we high for exactly the cycle following edge N+2. Exactly one write per rising edge; a held-high strobe never repeats the write.
- Bookkeeping, updated on the same edge that asserts mem_we:
  - written_mask[addr] <= 1.
  - err_overwrite |= old written_mask[addr].
  - checksum <= checksum + data, truncated to DW bits, overwrites included.
  - wr_count increments, saturating.
- all_loaded is combinational from written_mask.
- phase_infer rising while in WRITE: the in-flight write completes; the FSM then enters LOCKED.
- rst_n low mid-operation clears everything on that edge. A pending write is lost.

Optional Feature:
- Macro: SNN_LOADER_PARITY_EN.
- Defined:
  - adds input host_parity (1, driven on uio_in[2]) and output err_parity (1, sticky, reset 0, cleared by host_clr).
  - On rise, even parity is checked: ^{host_data, host_parity} must equal 0.
  - On mismatch: no mem_we, no bookkeeping update, err_parity set, FSM stays in IDLE.
- Undefined: both ports are absent and every rise is accepted.

Decomposition:
- Package snn_pkg holds:
  - ADDR_W and DW default constants, shared with Memory and Multilayer.
  - loader_state_t enum {IDLE, WRITE, LOCKED}.
- One sub-module, snn_sync_edge: 3-flop synchroniser plus rising-edge detector, with a synchronous active-low reset. It is reusable for other host pins.

Test Plan:
- Single write: phase=0, addr=0x3, data=0xA5, strobe 0→1 and held 10 cycles → exactly one mem_we pulse, 3 edges after first sample, addr=3, wdata=0xA5; mask=0x0008, count=1, checksum=0xA5.
- Full load: write addr i with data i+1 for i=0..15 → all_loaded=1, count=16, checksum=0x88, err_overwrite=0.
- Overwrite: write addr 5 with 0x10, then again with 0xF0 → two mem_we pulses, err_overwrite=1, checksum=0x00, count=2.
- Lock: phase=1, then 3 strobe pulses → mem_we stays 0; return to phase=0 with strobe held high → no write until the next rising edge.
- Clear/reset: host_clr=1 in the same cycle as rise → write dropped, bookkeeping=0. rst_n=0 one cycle after rise → mem_we never asserts, all outputs 0.
- Parity (SNN_LOADER_PARITY_EN): data=0x01, parity=0 → no write, err_parity=1. data=0x01, parity=1 → write accepted.
